// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: controller state encoding
// and the default byte width.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with a separate occupancy counter; full/empty decode the
// counter only, so pointer equality never has to be disambiguated.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // sample pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; the counter alone
    // decides which entries are valid, and this keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// UART transmit queue: buffers host bytes and hands them one at a time to the
// transmitter with a tx_start pulse, waiting for tx_done_tick between bytes.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow
);

    tx_state_e         state_q, state_d;
    logic              push, pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;

    // A write into a full queue is dropped even when a pop frees a slot in
    // the same cycle, because full reflects the registered count.
    assign push       = wr_en && !full;
    assign overflow_d = wr_en && full;

    sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!empty)      state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done_tick) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (state_q == IDLE && !empty) begin
            pop        = 1'b1;
            tx_start_d = 1'b1;
            tx_data_d  = fifo_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == WAIT_DONE);

endmodule
